// File: rtl/io_port_gpio_pkg.sv
// Shared register map and interrupt sense-mode encodings for the GPIO port.
// Also used by the core firmware address map.
package io_port_gpio_pkg;

    localparam logic [3:0] OFF_DIR      = 4'd0;
    localparam logic [3:0] OFF_DIRSET   = 4'd1;
    localparam logic [3:0] OFF_DIRCLR   = 4'd2;
    localparam logic [3:0] OFF_OUT      = 4'd3;
    localparam logic [3:0] OFF_OUTSET   = 4'd4;
    localparam logic [3:0] OFF_OUTCLR   = 4'd5;
    localparam logic [3:0] OFF_OUTTGL   = 4'd6;
    localparam logic [3:0] OFF_IN       = 4'd7;
    localparam logic [3:0] OFF_INTMASK  = 4'd8;
    localparam logic [3:0] OFF_INTCTRL  = 4'd9;
    localparam logic [3:0] OFF_INTFLAGS = 4'd10;
    localparam int unsigned NUM_REGS    = 11;

    typedef enum logic [1:0] {
        SENSE_BOTH = 2'd0,
        SENSE_RISE = 2'd1,
        SENSE_FALL = 2'd2,
        SENSE_OFF  = 2'd3
    } sense_e;

    function automatic logic edge_hit(sense_e mode, logic cur, logic prev);
        logic hit;
        case (mode)
            SENSE_BOTH: hit = cur ^ prev;
            SENSE_RISE: hit = cur & ~prev;
            SENSE_FALL: hit = ~cur & prev;
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/io_sync.sv
// Single-bit pad input synchroniser: SYNC_STAGES flops, cleared by async reset.
module io_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg <= '0;
        end else begin
            stg <= {stg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/io_port_gpio.sv
// Memory-mapped GPIO port: direction/output latches with set/clear/toggle
// aliases, synchronised inputs and edge-sensed, maskable interrupt flags.
module io_port_gpio
    import io_port_gpio_pkg::*;
#(
    parameter int BUS_ADDR_IO_WIDTH = 6,
    parameter int PORT_WIDTH        = 8,
    parameter int BASE_ADDR         = 0,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         io_re,
    input  logic                         io_we,
    input  logic [BUS_ADDR_IO_WIDTH-1:0] io_addr,
    input  logic [7:0]                   io_out,
    output logic [7:0]                   io_in,
    input  logic [PORT_WIDTH-1:0]        pin_in,
    output logic [PORT_WIDTH-1:0]        pin_out,
    output logic [PORT_WIDTH-1:0]        pin_dir,
    output logic                         irq
);

    localparam int PW = PORT_WIDTH;

    logic [31:0]   off_full;
    logic [3:0]    off;
    logic          hit;
    logic          wr_hit;
    logic          rd_hit;
    logic [PW-1:0] wd;

    logic [PW-1:0] dir;
    logic [PW-1:0] out_q;
    logic [PW-1:0] int_mask;
    sense_e        int_ctrl;
    logic [PW-1:0] int_flags;
    logic [PW-1:0] in_sync_p0;
    logic [PW-1:0] in_prev_p1;
    logic [PW-1:0] edge_set;
    logic [PW-1:0] flag_clr;
    logic [7:0]    rd_data;

    // Addresses below BASE_ADDR wrap to large offsets and never decode.
    assign off_full = 32'(io_addr) - 32'(BASE_ADDR);
    assign hit      = off_full < 32'(NUM_REGS);
    assign off      = off_full[3:0];
    assign wr_hit   = hit & io_we;
    assign rd_hit   = hit & io_re;
    assign wd       = io_out[PW-1:0];

    // Stage p0: synchronised pad value
    for (genvar i = 0; i < PW; i++) begin : g_sync
        io_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk(clk),
            .rst(rst),
            .d  (pin_in[i]),
            .q  (in_sync_p0[i])
        );
    end

    always_comb begin
        edge_set = '0;
        for (int i = 0; i < PW; i++) begin
            edge_set[i] = edge_hit(int_ctrl, in_sync_p0[i], in_prev_p1[i]) & int_mask[i];
        end
    end

    assign flag_clr = (wr_hit && off == OFF_INTFLAGS) ? wd : '0;

    // Stage p1: previous synchronised value and the flags it produces
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir        <= '0;
            out_q      <= '0;
            int_mask   <= '0;
            int_ctrl   <= SENSE_BOTH;
            int_flags  <= '0;
            in_prev_p1 <= '0;
        end else begin
            in_prev_p1 <= in_sync_p0;
            // A new edge in the same cycle as a clear keeps the flag set.
            int_flags  <= (int_flags & ~flag_clr) | edge_set;
            if (wr_hit) begin
                case (off)
                    OFF_DIR:     dir      <= wd;
                    OFF_DIRSET:  dir      <= dir | wd;
                    OFF_DIRCLR:  dir      <= dir & ~wd;
                    OFF_OUT:     out_q    <= wd;
                    OFF_OUTSET:  out_q    <= out_q | wd;
                    OFF_OUTCLR:  out_q    <= out_q & ~wd;
                    OFF_OUTTGL:  out_q    <= out_q ^ wd;
                    OFF_INTMASK: int_mask <= wd;
                    OFF_INTCTRL: int_ctrl <= sense_e'(io_out[1:0]);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_DIR, OFF_DIRSET, OFF_DIRCLR:            rd_data[PW-1:0] = dir;
            OFF_OUT, OFF_OUTSET, OFF_OUTCLR, OFF_OUTTGL: rd_data[PW-1:0] = out_q;
            OFF_IN:                                     rd_data[PW-1:0] = in_sync_p0;
            OFF_INTMASK:                                rd_data[PW-1:0] = int_mask;
            OFF_INTCTRL:                                rd_data[1:0]    = int_ctrl;
            OFF_INTFLAGS:                               rd_data[PW-1:0] = int_flags;
            default: ;
        endcase
    end

    assign io_in   = rd_hit ? rd_data : 8'bz;
    assign irq     = |(int_flags & int_mask);
    assign pin_out = out_q;
    assign pin_dir = dir;

endmodule

// File: doc/io_port_gpio.md
IO_PORT_GPIO -- requirements
Module: io_port_gpio

Interface
REQ-001 SHALL have parameter BUS_ADDR_IO_WIDTH, default 6: width of io_addr.
REQ-002 SHALL have parameter PORT_WIDTH, default 8, legal range 1..8: number of pins.
REQ-003 SHALL have parameter BASE_ADDR, default 0: I/O address of register offset 0.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: input synchroniser depth.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 io_re  in  1  core I/O read strobe.
REQ-008 io_we  in  1  core I/O write strobe.
REQ-009 io_addr  in  BUS_ADDR_IO_WIDTH  core I/O address.
REQ-010 io_out  in  8  write data from core.
REQ-011 io_in  out  8  read data to core; tri-state when not selected.
REQ-012 pin_in  in  PORT_WIDTH  asynchronous pad inputs.
REQ-013 pin_out  out  PORT_WIDTH  output latch value.
REQ-014 pin_dir  out  PORT_WIDTH  output enable, 1 = pin driven.
REQ-015 irq  out  1  level interrupt request.

Function
REQ-016 Register offsets from BASE_ADDR SHALL be: 0 DIR, 1 DIRSET, 2 DIRCLR, 3 OUT, 4 OUTSET, 5 OUTCLR, 6 OUTTGL, 7 IN, 8 INTMASK, 9 INTCTRL, 10 INTFLAGS.
REQ-017 A register SHALL be selected when io_addr equals BASE_ADDR+offset for offset 0..10 and io_re or io_we is high; other addresses SHALL cause no state change and leave io_in at 'z.
REQ-018 Writes SHALL take effect on the rising clk edge with io_we high; only bits [PORT_WIDTH-1:0] are stored.
REQ-019 DIRSET/OUTSET SHALL OR, DIRCLR/OUTCLR SHALL AND-NOT, and OUTTGL SHALL XOR io_out into DIR/OUT respectively.
REQ-020 Reads SHALL be combinational in the cycle io_re is high; DIR/DIRSET/DIRCLR return DIR, OUT/OUTSET/OUTCLR/OUTTGL return OUT, and unused upper bits read 0.
REQ-021 io_re and io_we both high in one cycle SHALL perform the write and drive read data from pre-write state.
REQ-022 pin_in SHALL pass through a SYNC_STAGES flop chain per bit; IN SHALL read the last stage; writes to IN SHALL be ignored.
REQ-023 A pin change settling before edge 1 SHALL be visible in IN after edge SYNC_STAGES.
REQ-024 Edge detection SHALL compare the last sync stage with a one-cycle-delayed copy (prev).
REQ-025 INTCTRL[1:0] SHALL select the sense mode: 0 both edges, 1 rising, 2 falling, 3 disabled; INTCTRL[7:2] read 0.
REQ-026 An INTFLAGS bit SHALL be set at edge SYNC_STAGES+1 after a qualifying edge, only when its INTMASK bit is 1.
REQ-027 INTFLAGS SHALL be write-1-to-clear; if a set and a clear of the same bit fall in one cycle, set SHALL win.
REQ-028 irq SHALL equal the OR of (INTFLAGS AND INTMASK), with no registered delay.
REQ-029 pin_out SHALL equal OUT and pin_dir SHALL equal DIR, direct from registers.

Reset
REQ-030 While rst is low, DIR, OUT, INTMASK, INTCTRL, INTFLAGS, sync stages and prev SHALL all be 0, so pin_out=0, pin_dir=0 and irq=0, regardless of clk.
REQ-031 Reset asserted mid-operation SHALL clear pending flags immediately, and no edge SHALL be reported for the reset-induced transition while INTMASK=0.

Structure
REQ-032 Register offsets and sense-mode encodings SHALL live in the shared core package/header, reused by the core firmware map.
REQ-033 The per-bit synchroniser SHALL be a sub-module io_sync, parameterised by SYNC_STAGES, with the same async active-low reset.

Verification
REQ-034 Reset, then write DIR=0xF0 and OUTSET=0x81 -> pin_dir=0xF0, pin_out=0x81; OUTTGL=0x03 -> pin_out=0x82; OUTCLR=0x80 -> pin_out=0x02.
REQ-035 Drive pin_in 0x00->0x5A (SYNC_STAGES=2) -> IN reads 0x00 through edge 1 and 0x5A from edge 2.
REQ-036 INTMASK=0x01, INTCTRL=1, pin0 rises -> INTFLAGS=0x01 and irq=1 at edge 3; pin0 falls -> no new flag.
REQ-037 With INTFLAGS=0x01, write INTFLAGS=0x01 in the same cycle a new rising edge flags bit 0 -> bit 0 stays 1; a later write of 0x01 alone -> irq=0.
REQ-038 Write to BASE_ADDR+11 and BASE_ADDR+7 -> all registers unchanged and io_in='z outside read cycles; PORT_WIDTH=4 read of DIR after writing 0xFF -> 0x0F.
REQ-039 Assert rst low mid-sequence with irq=1 -> irq, pin_out and pin_dir go 0 without a clk edge.
